alu4_op_stage: RTL

- Pipelined 4-bit ALU stage that consumes the team's 2-input gate cells (NOR2 and relatives) as its logic function set. It adds arithmetic, flags and flow control around them.
- Sits directly downstream of the gate library. It accepts operand/opcode transactions from the operand register file and delivers results plus flags to the result/flag register.
- Two-stage valid/ready pipeline with full backpressure and a completed-operation counter.

---
 rtl/alu4_pkg.sv | 47 ++++
 rtl/alu4_func.sv | 72 +++++++
 rtl/alu4_op_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/alu4_pkg.sv
// alu4_pkg -- shared definitions for the alu4 operation stage.
//   * op_e        : 3-bit opcode encoding (OP_NOR .. OP_PASS)
//   * FLAG_*      : bit positions of Z/C/V inside a packed flag vector
//   * ALU_W_DEFAULT: default operand/result width
//   * nor2/nand2/and2/or2/xor2: single-bit 2-input gate cells used to build
//     the logic function set of the ALU.
package alu4_pkg;

   localparam int ALU_W_DEFAULT = 4;

   typedef enum logic [2:0] {
      OP_NOR  = 3'b000,
      OP_NAND = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_ADD  = 3'b101,
      OP_SUB  = 3'b110,
      OP_PASS = 3'b111
   } op_e;

   localparam int FLAG_Z      = 0;
   localparam int FLAG_C      = 1;
   localparam int FLAG_V      = 2;
   localparam int FLAG_N_BITS = 3;

   function automatic logic nor2(input logic a, input logic b);
      return ~(a | b);
   endfunction

   function automatic logic nand2(input logic a, input logic b);
      return ~(a & b);
   endfunction

   function automatic logic and2(input logic a, input logic b);
      return a & b;
   endfunction

   function automatic logic or2(input logic a, input logic b);
      return a | b;
   endfunction

   function automatic logic xor2(input logic a, input logic b);
      return a ^ b;
   endfunction

endpackage

// File: rtl/alu4_func.sv
// alu4_func -- purely combinational ALU function block.
// Ports:
//   A, B   (in,  W)  operands
//   Op     (in,  op_e) opcode
//   result (out, W)  function result
//   Z      (out)     result == 0
//   C      (out)     carry out (ADD) / no-borrow (SUB), 0 otherwise
//   V      (out)     signed overflow (ADD/SUB), 0 otherwise
module alu4_func
   import alu4_pkg::*;
#(
   parameter int W = ALU_W_DEFAULT
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  op_e          Op,
   output logic [W-1:0] result,
   output logic         Z,
   output logic         C,
   output logic         V
);

   logic [W-1:0] nor_v, nand_v, and_v, or_v, xor_v;

   // Bitwise logic ops, one gate cell per bit.
   for (genvar gi = 0; gi < W; gi++) begin : g_bit
      assign nor_v[gi]  = nor2 (A[gi], B[gi]);
      assign nand_v[gi] = nand2(A[gi], B[gi]);
      assign and_v[gi]  = and2 (A[gi], B[gi]);
      assign or_v[gi]   = or2  (A[gi], B[gi]);
      assign xor_v[gi]  = xor2 (A[gi], B[gi]);
   end

   // Single adder shared by ADD and SUB; SUB is A + ~B + 1 so the carry out
   // doubles as the no-borrow flag.
   logic         is_sub;
   logic [W-1:0] b_eff;
   logic [W:0]   sum;

   always_comb begin
      is_sub = (Op == OP_SUB);
      b_eff  = is_sub ? ~B : B;
      sum    = {1'b0, A} + {1'b0, b_eff} + {{W{1'b0}}, is_sub};
   end

   always_comb begin
      result = '0;
      C      = 1'b0;
      V      = 1'b0;
      unique case (Op)
         OP_NOR:  result = nor_v;
         OP_NAND: result = nand_v;
         OP_AND:  result = and_v;
         OP_OR:   result = or_v;
         OP_XOR:  result = xor_v;
         OP_ADD: begin
            result = sum[W-1:0];
            C      = sum[W];
            V      = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
         end
         OP_SUB: begin
            result = sum[W-1:0];
            C      = sum[W];
            V      = (A[W-1] != B[W-1]) && (sum[W-1] != A[W-1]);
         end
         OP_PASS: result = A;
         default: result = '0;
      endcase
      Z = (result == '0);
   end

endmodule

// File: rtl/alu4_op_stage.sv
// alu4_op_stage -- two-stage valid/ready ALU pipeline.
//   Stage 1 registers A/B/Op, stage 2 registers result and flags.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   A, B (W), Op (3)  transaction payload, qualified by in_valid
//   in_valid/in_ready upstream handshake (in_ready low while rst high)
//   Output (W), Z, C, V  result and flags, qualified by out_valid
//   out_valid/out_ready  downstream handshake
//   op_count (CNT_W)  count of delivered results, wraps
module alu4_op_stage
   import alu4_pkg::*;
#(
   parameter int W     = ALU_W_DEFAULT,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     A,
   input  logic [W-1:0]     B,
   input  logic [2:0]       Op,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [W-1:0]     Output,
   output logic             Z,
   output logic             C,
   output logic             V,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] op_count
);

   // Stage 1
   logic [W-1:0] a_q, a_d, b_q, b_d;
   op_e          op_q, op_d;
   logic         s1_valid_q, s1_valid_d;

   // Stage 2
   logic [W-1:0]           res_q, res_d;
   logic [FLAG_N_BITS-1:0] flags_q, flags_d;
   logic                   s2_valid_q, s2_valid_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Function block output
   logic [W-1:0]           f_res;
   logic [FLAG_N_BITS-1:0] f_flags;

   alu4_func #(.W(W)) u_func (
      .A      (a_q),
      .B      (b_q),
      .Op     (op_q),
      .result (f_res),
      .Z      (f_flags[FLAG_Z]),
      .C      (f_flags[FLAG_C]),
      .V      (f_flags[FLAG_V])
   );

   // Handshake: in_ready looks only at state, rst and out_ready, never at
   // in_valid, so upstream may derive in_valid from in_ready safely.
   logic s2_accept, s1_adv, capture, deliver;

   always_comb begin
      s2_accept = !s2_valid_q || out_ready;
      s1_adv    = s1_valid_q && s2_accept;
      in_ready  = !rst && (!s1_valid_q || s1_adv);
      capture   = in_valid && in_ready;
      deliver   = s2_valid_q && out_ready;
   end

   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      s1_valid_d = s1_valid_q;
      res_d      = res_q;
      flags_d    = flags_q;
      s2_valid_d = s2_valid_q;
      cnt_d      = cnt_q;

      if (capture) begin
         a_d        = A;
         b_d        = B;
         op_d       = op_e'(Op);
         s1_valid_d = 1'b1;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      // Result registers load only on advance, so they stay frozen while
      // the output is stalled.
      if (s1_adv) begin
         res_d      = f_res;
         flags_d    = f_flags;
         s2_valid_d = 1'b1;
      end else if (deliver) begin
         s2_valid_d = 1'b0;
      end

      if (deliver) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= OP_NOR;
         s1_valid_q <= 1'b0;
         res_q      <= '0;
         flags_q    <= '0;
         s2_valid_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         s1_valid_q <= s1_valid_d;
         res_q      <= res_d;
         flags_q    <= flags_d;
         s2_valid_q <= s2_valid_d;
         cnt_q      <= cnt_d;
      end
   end

   assign Output    = res_q;
   assign Z         = flags_q[FLAG_Z];
   assign C         = flags_q[FLAG_C];
   assign V         = flags_q[FLAG_V];
   assign out_valid = s2_valid_q;
   assign op_count  = cnt_q;

endmodule
